// File: rtl/serial_link_sync_ctrl.sv
// Comma-based byte alignment and lock controller for the serial receive path.
// Hunts for COMMA bitwise, confirms it on a fixed boundary, then delivers data bytes while locked.
module serial_link_sync_ctrl #(
   parameter logic [7:0] COMMA      = 8'hBC,
   parameter int         LOCK_COUNT = 4,
   parameter int         MAX_GAP    = 64
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic       enable,
   input  logic       data_in,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       comma_det,
   output logic       lock,
   output logic       loss_of_lock,
   output logic [1:0] state
);

   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam int GW = $clog2(MAX_GAP + 1);
   localparam logic [CW-1:0] LOCK_C = CW'(LOCK_COUNT);
   localparam logic [GW-1:0] GAP_C  = GW'(MAX_GAP);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          st;
   logic [7:0]      sr;
   logic [2:0]      bit_cnt;
   logic [CW-1:0]   comma_cnt;
   logic [GW-1:0]   gap_cnt;

   logic [7:0]      nxt;
   logic            is_comma;
   logic            boundary;
   logic [CW-1:0]   comma_inc;
   logic [GW-1:0]   gap_inc;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      nxt       = {sr[6:0], data_in};
      is_comma  = (nxt == COMMA);
      boundary  = (bit_cnt == 3'd7);
      comma_inc = (comma_cnt == LOCK_C) ? comma_cnt : comma_cnt + CW'(1);
      gap_inc   = (gap_cnt == GAP_C) ? gap_cnt : gap_cnt + GW'(1);
   end

   assign state = st;

   // NOTE: all state lives in this one block and uses non-blocking assignments only.
   always_ff @(posedge clk_8f or posedge reset) begin
      if (reset) begin
         st           <= HUNT;
         sr           <= '0;
         bit_cnt      <= '0;
         comma_cnt    <= '0;
         gap_cnt      <= '0;
         byte_out     <= 8'h00;
         byte_valid   <= 1'b0;
         comma_det    <= 1'b0;
         lock         <= 1'b0;
         loss_of_lock <= 1'b0;
      end else begin
         sr           <= nxt;
         byte_valid   <= 1'b0;
         comma_det    <= 1'b0;
         loss_of_lock <= 1'b0;

         if (!enable) begin
            st        <= HUNT;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            gap_cnt   <= '0;
            lock      <= 1'b0;
         end else begin
            case (st)
               HUNT: begin
                  bit_cnt <= '0;
                  if (is_comma) begin
                     st        <= SYNC;
                     comma_cnt <= CW'(1);
                  end
               end

               SYNC: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (boundary) begin
                     if (is_comma) begin
                        comma_det <= 1'b1;
                        comma_cnt <= comma_inc;
                        if (comma_inc == LOCK_C) begin
                           st      <= LOCKED;
                           lock    <= 1'b1;
                           gap_cnt <= '0;
                        end
                     end else begin
                        // The rejected byte is dropped; hunting restarts on fresh bits.
                        st        <= HUNT;
                        bit_cnt   <= '0;
                        comma_cnt <= '0;
                     end
                  end
               end

               LOCKED: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (boundary) begin
                     byte_out <= nxt;
                     if (is_comma) begin
                        comma_det <= 1'b1;
                        gap_cnt   <= '0;
                     end else begin
                        byte_valid <= 1'b1;
                        gap_cnt    <= gap_inc;
                        if (gap_inc == GAP_C) begin
                           st           <= HUNT;
                           lock         <= 1'b0;
                           loss_of_lock <= 1'b1;
                           bit_cnt      <= '0;
                           comma_cnt    <= '0;
                           gap_cnt      <= '0;
                        end
                     end
                  end
               end

               default: begin
                  st        <= HUNT;
                  bit_cnt   <= '0;
                  comma_cnt <= '0;
                  gap_cnt   <= '0;
                  lock      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_link_sync_ctrl.sv
// Directed bench for serial_link_sync_ctrl: one DUT at default MAX_GAP, one at MAX_GAP=4.
// Each cycle's outputs are logged at posedge+1 and checked by per-scenario tasks.
module tb_serial_link_sync_ctrl;

   logic clk_8f = 1'b0;
   logic reset  = 1'b1;
   logic enable = 1'b1;
   logic data_in = 1'b0;

   logic [7:0] d_byte_out, g_byte_out;
   logic       d_byte_valid, g_byte_valid;
   logic       d_comma_det, g_comma_det;
   logic       d_lock, g_lock;
   logic       d_loss, g_loss;
   logic [1:0] d_state, g_state;

   bit sel = 1'b0;   // 0: default DUT, 1: MAX_GAP=4 DUT

   logic [7:0] o_byte_out;
   logic       o_byte_valid, o_comma_det, o_lock, o_loss;
   logic [1:0] o_state;

   assign o_byte_out   = sel ? g_byte_out   : d_byte_out;
   assign o_byte_valid = sel ? g_byte_valid : d_byte_valid;
   assign o_comma_det  = sel ? g_comma_det  : d_comma_det;
   assign o_lock       = sel ? g_lock       : d_lock;
   assign o_loss       = sel ? g_loss       : d_loss;
   assign o_state      = sel ? g_state      : d_state;

   serial_link_sync_ctrl dut (
      .clk_8f(clk_8f), .reset(reset), .enable(enable), .data_in(data_in),
      .byte_out(d_byte_out), .byte_valid(d_byte_valid), .comma_det(d_comma_det),
      .lock(d_lock), .loss_of_lock(d_loss), .state(d_state)
   );

   serial_link_sync_ctrl #(.MAX_GAP(4)) dut_gap (
      .clk_8f(clk_8f), .reset(reset), .enable(enable), .data_in(data_in),
      .byte_out(g_byte_out), .byte_valid(g_byte_valid), .comma_det(g_comma_det),
      .lock(g_lock), .loss_of_lock(g_loss), .state(g_state)
   );

   always #5 clk_8f = ~clk_8f;

   int vectors = 0;
   int miscompares = 0;

   int         cyc;
   int         valid_cyc[$];
   logic [7:0] valid_byte[$];
   int         comma_cyc[$];
   int         loss_cyc[$];
   logic [1:0] state_log[$];
   logic       lock_log[$];
   int         lock_rise_cyc;
   bit         lock_seen;

   task automatic clear_log();
      cyc = 0;
      valid_cyc.delete();
      valid_byte.delete();
      comma_cyc.delete();
      loss_cyc.delete();
      state_log.delete();
      lock_log.delete();
      lock_rise_cyc = -1;
      lock_seen = 1'b0;
   endtask

   task automatic bit_step(input logic b);
      data_in = b;
      @(posedge clk_8f);
      #1;
      cyc++;
      if (o_byte_valid) begin
         valid_cyc.push_back(cyc);
         valid_byte.push_back(o_byte_out);
      end
      if (o_comma_det) comma_cyc.push_back(cyc);
      if (o_loss) loss_cyc.push_back(cyc);
      if (o_lock) lock_seen = 1'b1;
      if (o_lock && lock_rise_cyc < 0) lock_rise_cyc = cyc;
      state_log.push_back(o_state);
      lock_log.push_back(o_lock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bit_step(b[i]);
   endtask

   task automatic do_reset();
      @(negedge clk_8f);
      reset = 1'b1;
      enable = 1'b1;
      data_in = 1'b0;
      @(negedge clk_8f);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [14:0] outs;
      #1;
      outs = {o_byte_out, o_byte_valid, o_comma_det, o_lock, o_loss, o_state, 1'b0};
      vectors++;
      if (outs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_initial outputs=%h expected=0", outs);
      end
      @(negedge clk_8f);
      reset = 1'b0;
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      send_byte(8'h12);
      vectors++;
      if (o_lock !== 1'b1 || o_byte_out !== 8'h12) begin
         miscompares++;
         $display("FAIL reset_prelock lock=%b byte_out=%h expected lock=1 byte_out=12", o_lock, o_byte_out);
      end
      bit_step(1'b1);
      bit_step(1'b0);
      bit_step(1'b1);
      #2;
      reset = 1'b1;
      #1;
      outs = {o_byte_out, o_byte_valid, o_comma_det, o_lock, o_loss, o_state, 1'b0};
      vectors++;
      if (outs !== 15'h0) begin
         miscompares++;
         $display("FAIL reset_async outputs=%h expected=0", outs);
      end
      @(negedge clk_8f);
      reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         bit_step(1'b0);
         outs = {o_byte_out, o_byte_valid, o_comma_det, o_lock, o_loss, o_state, 1'b0};
         vectors++;
         if (outs !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_idle cycle %0d outputs=%h expected=0", k, outs);
         end
      end
   endtask

   task automatic test_lock_acquisition();
      logic [7:0] c = 8'hBC;
      sel = 1'b0;
      do_reset();
      clear_log();
      bit_step(1'b1);
      bit_step(1'b0);
      bit_step(1'b1);
      for (int i = 7; i >= 0; i--) begin
         bit_step(c[i]);
         if (i == 1) begin
            vectors++;
            if (o_state !== 2'd0) begin
               miscompares++;
               $display("FAIL lock_hunt_before_lsb state=%0d expected=0", o_state);
            end
         end
      end
      vectors++;
      if (o_state !== 2'd1) begin
         miscompares++;
         $display("FAIL lock_sync_entry state=%0d expected=1", o_state);
      end
      for (int k = 0; k < 3; k++) send_byte(8'hBC);
      vectors++;
      if (comma_cyc.size() !== 3 || comma_cyc[0] !== 19 || comma_cyc[2] !== 35) begin
         miscompares++;
         $display("FAIL lock_comma_det count=%0d expected=3 at cycles 19,27,35", comma_cyc.size());
      end
      vectors++;
      if (lock_rise_cyc !== 35 || state_log[34] !== 2'd2) begin
         miscompares++;
         $display("FAIL lock_rise cycle=%0d state=%0d expected cycle=35 state=2", lock_rise_cyc, state_log[34]);
      end
   endtask

   task automatic test_data_delivery();
      clear_log();
      send_byte(8'h12);
      send_byte(8'hBC);
      send_byte(8'hA5);
      vectors++;
      if (valid_cyc.size() !== 2) begin
         miscompares++;
         $display("FAIL data_valid_count got=%0d expected=2", valid_cyc.size());
      end else begin
         vectors++;
         if (valid_byte[0] !== 8'h12 || valid_byte[1] !== 8'hA5) begin
            miscompares++;
            $display("FAIL data_bytes got=%h,%h expected=12,a5", valid_byte[0], valid_byte[1]);
         end
         vectors++;
         if (valid_cyc[0] !== 8 || valid_cyc[1] - valid_cyc[0] !== 16) begin
            miscompares++;
            $display("FAIL data_spacing first=%0d gap=%0d expected first=8 gap=16", valid_cyc[0], valid_cyc[1] - valid_cyc[0]);
         end
      end
      vectors++;
      if (comma_cyc.size() !== 1 || comma_cyc[0] !== 16) begin
         miscompares++;
         $display("FAIL data_comma count=%0d expected=1 at cycle 16", comma_cyc.size());
      end
   endtask

   task automatic test_false_sync();
      sel = 1'b0;
      do_reset();
      clear_log();
      send_byte(8'hBC);
      send_byte(8'hBC);
      send_byte(8'h3C);
      vectors++;
      if (state_log[22] !== 2'd1 || state_log[23] !== 2'd0) begin
         miscompares++;
         $display("FAIL false_sync_state cyc23=%0d cyc24=%0d expected 1,0", state_log[22], state_log[23]);
      end
      vectors++;
      if (lock_seen !== 1'b0 || comma_cyc.size() !== 1) begin
         miscompares++;
         $display("FAIL false_sync_lock lock_seen=%b commas=%0d expected 0,1", lock_seen, comma_cyc.size());
      end
   endtask

   task automatic test_gap_timeout();
      sel = 1'b1;
      do_reset();
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      vectors++;
      if (o_lock !== 1'b1) begin
         miscompares++;
         $display("FAIL gap_initial_lock lock=%b expected=1", o_lock);
      end
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'h55);
      vectors++;
      if (valid_cyc.size() !== 4 || valid_byte[3] !== 8'h55) begin
         miscompares++;
         $display("FAIL gap_valid_count got=%0d expected=4", valid_cyc.size());
      end
      vectors++;
      if (loss_cyc.size() !== 1 || loss_cyc[0] !== 32 || valid_cyc[3] !== 32) begin
         miscompares++;
         $display("FAIL gap_loss count=%0d expected=1 coincident with 4th valid at 32", loss_cyc.size());
      end
      vectors++;
      if (lock_log[30] !== 1'b1 || lock_log[31] !== 1'b0 || state_log[31] !== 2'd0) begin
         miscompares++;
         $display("FAIL gap_drop lock31=%b lock32=%b state32=%0d expected 1,0,0", lock_log[30], lock_log[31], state_log[31]);
      end
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      vectors++;
      if (lock_rise_cyc !== 32 || o_state !== 2'd2) begin
         miscompares++;
         $display("FAIL gap_relock rise=%0d state=%0d expected 32,2", lock_rise_cyc, o_state);
      end
      sel = 1'b0;
   endtask

   task automatic test_enable_drop();
      sel = 1'b0;
      do_reset();
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      clear_log();
      bit_step(1'b0);
      bit_step(1'b0);
      bit_step(1'b0);
      enable = 1'b0;
      bit_step(1'b0);
      vectors++;
      if (o_lock !== 1'b0 || o_state !== 2'd0) begin
         miscompares++;
         $display("FAIL enable_drop lock=%b state=%0d expected 0,0", o_lock, o_state);
      end
      enable = 1'b1;
      for (int k = 0; k < 4; k++) bit_step(1'b0);
      vectors++;
      if (loss_cyc.size() !== 0 || valid_cyc.size() !== 0 || o_state !== 2'd0) begin
         miscompares++;
         $display("FAIL enable_no_loss loss=%0d valid=%0d state=%0d expected 0,0,0", loss_cyc.size(), valid_cyc.size(), o_state);
      end
      clear_log();
      for (int k = 0; k < 4; k++) send_byte(8'hBC);
      vectors++;
      if (lock_rise_cyc !== 32 || o_state !== 2'd2) begin
         miscompares++;
         $display("FAIL enable_relock rise=%0d state=%0d expected 32,2", lock_rise_cyc, o_state);
      end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_lock_acquisition();
      test_data_delivery();
      test_false_sync();
      test_gap_timeout();
      test_enable_drop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_link_sync_ctrl.md
# serial_link_sync_ctrl

Bit-alignment and lock controller for the serial receive path, running in the `clk_8f` domain. Hunts the incoming MSB-first bit stream for the comma byte 0xBC, fixes the byte boundary, and declares lock after a run of commas on that boundary. While locked it emits each non-comma byte with a one-cycle strobe, and drops back to hunting if commas stop arriving. It sequences the downstream parallelizer and replaces its ad-hoc active/BC counting.

## Interface
- `COMMA`, 8'hBC: alignment/idle byte.
- `LOCK_COUNT`, 4: consecutive boundary-aligned commas, including the first, needed to lock (≥2).
- `MAX_GAP`, 64: consecutive non-comma bytes tolerated while locked (≥1).
- `clk_8f` input 1: bit clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs.
- `enable` input 1: low forces HUNT synchronously and clears counters.
- `data_in` input 1: serial data, MSB of each byte first.
- `byte_out` output 8: last completed byte (registered).
- `byte_valid` output 1: one-cycle pulse; `byte_out` is a non-comma data byte while locked.
- `comma_det` output 1: one-cycle pulse; a comma completed on the current byte boundary (SYNC or LOCKED).
- `lock` output 1: level; high only in LOCKED.
- `loss_of_lock` output 1: one-cycle pulse on LOCKED→HUNT caused by gap timeout.
- `state` output 2: 0 HUNT, 1 SYNC, 2 LOCKED.

## Operation
- Shift register `sr[7:0]`; every edge `nxt = {sr[6:0], data_in}`, `sr <= nxt`. `sr` is kept updated in all states, including while `enable` is low.
- `bit_cnt[2:0]`: in SYNC and LOCKED it counts 0..7 and wraps. A byte boundary is an edge with `bit_cnt==7`; `nxt` is the completed byte.
- HUNT: bitwise search. If `nxt==COMMA`, go to SYNC with `bit_cnt<=0` and `comma_cnt<=1`. `comma_det` is not pulsed in HUNT.
- SYNC, at a boundary:
  - If `nxt==COMMA`: pulse `comma_det` and increment `comma_cnt`. When the increment reaches `LOCK_COUNT`, go to LOCKED with `gap_cnt<=0`.
  - If `nxt!=COMMA`: go to HUNT and clear `comma_cnt`. The rejected byte is not re-searched.
- LOCKED, at a boundary:
  - `byte_out<=nxt` at every boundary.
  - Comma: pulse `comma_det` and set `gap_cnt<=0`. `byte_valid` stays low.
  - Non-comma: pulse `byte_valid` and increment `gap_cnt`. If the new `gap_cnt==MAX_GAP`, go to HUNT, pulse `loss_of_lock`, and drop `lock`. That final byte is still delivered with `byte_valid`.
- `enable` low: next state is HUNT. `comma_cnt`, `gap_cnt` and `bit_cnt` clear. `lock`, `byte_valid`, `comma_det` and `loss_of_lock` are low the following cycle. No `loss_of_lock` pulse is generated.
- `enable` has priority over all other transitions. `reset` has priority over everything.
- Widths: `comma_cnt` is `$clog2(LOCK_COUNT+1)` bits and saturates. `gap_cnt` is `$clog2(MAX_GAP+1)` bits and never wraps.

## Timing
- Reset values:
  - `state=HUNT`, `sr=0`, `bit_cnt=0`, `comma_cnt=0`, `gap_cnt=0`.
  - `byte_out=8'h00`.
  - `byte_valid=0`, `comma_det=0`, `lock=0`, `loss_of_lock=0`.
- All outputs are registered. Pulses appear in the cycle after the edge that samples the byte's LSB.
- Latency from a byte's first bit to `byte_valid`: 8 `clk_8f` edges; the pulse is visible after the 8th.
- Lock time from the first comma bit: 8·`LOCK_COUNT` edges (32 by default). `lock` rises together with the final comma's `comma_det`.
- Throughput: at most one `byte_valid` per 8 cycles. Pulses are exactly 1 cycle wide.
- Reset mid-byte while LOCKED: outputs clear immediately and asynchronously. The partial byte is discarded and operation resumes in HUNT.

## Test plan
- Reset/idle: assert `reset` mid-stream, then stream all zeros for 100 cycles.
  - Required: all outputs at their reset values and `state=0` throughout.
- Lock acquisition: 3 random bits, then 4×0xBC.
  - Required: SYNC begins 1 cycle after the first comma's LSB is sampled.
  - Required: `comma_det` pulses 3 times, with `lock=1` and `state=2` coinciding with the 3rd pulse.
- Data delivery: lock, then send 0x12, 0xBC, 0xA5.
  - Required: `byte_valid` pulses with `byte_out` 0x12, then 0xA5, spaced 16 cycles apart.
  - Required: 0xBC produces `comma_det` only.
- False sync: 0xBC, 0xBC, then 0x3C.
  - Required: returns to HUNT at the 0x3C boundary with `lock` never asserted.
- Gap timeout: `MAX_GAP=4`; after lock, send 4× 0x55.
  - Required: 4 `byte_valid` pulses; `loss_of_lock` coincides with the 4th, then `lock=0` and `state=0`.
  - Required: a subsequent 4×0xBC relocks.
- Enable drop: deassert `enable` for 1 cycle mid-byte while locked.
  - Required: `lock=0` next cycle, no `loss_of_lock`, HUNT resumes, and relock occurs on the next 4 commas.
